// File: rtl/apb_wait_slave.sv
// rtl/apb_wait_slave.sv - APB completer with programmable wait states, error response and RO counter/ID registers
module apb_wait_slave #(
    parameter int         DEPTH       = 64,
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] ID_VAL      = 8'hA5
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W  = 9'(DEPTH);
    localparam logic [3:0] WAIT_W   = 4'(WAIT_CYCLES);
    localparam logic [7:0] CNT_ADDR = 8'hFE;
    localparam logic [7:0] ID_ADDR  = 8'hFF;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [7:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          write_q;
    logic [7:0]    wr_count;
    logic [7:0]    regs [DEPTH];

    logic          setup;
    logic [7:0]    cur_addr;
    logic          cur_write;
    logic [AW-1:0] idx;
    logic          in_file;
    logic          cur_err;
    logic [7:0]    rd_val;
    logic [7:0]    done_rdata;

    // In IDLE the live bus is decoded so a zero-wait access completes straight from setup.
    always_comb begin
        setup     = PSEL && !PENABLE;
        cur_addr  = (state == IDLE) ? PADDR : addr_q;
        cur_write = (state == IDLE) ? PWRITE : write_q;
        idx       = cur_addr[AW-1:0];
        in_file   = {1'b0, cur_addr} < DEPTH_W;
        rd_val    = 8'h00;
        if (in_file)
            rd_val = regs[idx];
        else if (cur_addr == CNT_ADDR)
            rd_val = wr_count;
        else if (cur_addr == ID_ADDR)
            rd_val = ID_VAL;
        cur_err    = cur_write ? !in_file
                               : !(in_file || cur_addr == CNT_ADDR || cur_addr == ID_ADDR);
        done_rdata = (cur_err || cur_write) ? 8'h00 : rd_val;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state    <= IDLE;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= 8'h00;
            cnt      <= 4'd0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            write_q  <= 1'b0;
            wr_count <= 8'h00;
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= 8'h00;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= 8'h00;
            case (state)
                IDLE: begin
                    if (setup) begin
                        addr_q  <= PADDR;
                        wdata_q <= PWDATA;
                        write_q <= PWRITE;
                        cnt     <= WAIT_W;
                        if (WAIT_CYCLES == 0) begin
                            state   <= DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= cur_err;
                            PRDATA  <= done_rdata;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= cur_err;
                            PRDATA  <= done_rdata;
                        end
                    end
                end
                DONE: begin
                    if (write_q && !cur_err) begin
                        regs[idx] <= wdata_q;
                        wr_count  <= wr_count + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb/tb_apb_wait_slave.sv - bench for apb_wait_slave with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
module tb_apb_wait_slave;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic       clk = 1'b0;
    logic       presetn;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [7:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];

    always #5 clk = ~clk;

    apb_wait_slave #(.DEPTH(64), .WAIT_CYCLES(W0), .ID_VAL(8'hA5)) u_dut0 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_wait_slave #(.DEPTH(64), .WAIT_CYCLES(W1), .ID_VAL(8'hA5)) u_dut1 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
        bit         scramble;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit scr, output logic [7:0] rd, output logic er, output int lat);
        @(negedge clk);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        @(negedge clk);
        penable[d] = 1'b1;
        if (scr) begin
            paddr[d]  = ~a;
            pwdata[d] = ~wd;
            pwrite[d] = ~wr;
        end
        lat = 1;
        while (pready[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = prdata[d];
        er = pslverr[d];
    endtask

    task automatic run(input int d, input string name, input bit wr, input logic [7:0] a,
                       input logic [7:0] wd, input bit scr, input logic [7:0] exp_rd,
                       input logic exp_err);
        exp_t       e;
        logic [7:0] rd;
        logic       er;
        int         lat;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = 1 + ((d == 0) ? W0 : W1);
        sb.push_back(e);
        xfer(d, wr, a, wd, scr, rd, er, lat);
        e = sb.pop_front();
        check({name, "/latency"}, lat, e.lat);
        check({name, "/prdata"}, rd, e.rdata);
        check({name, "/pslverr"}, er, e.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h05, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 8'h11, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h3F, 8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h3F, 8'h00, 8'h5A, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h40, 8'h99, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 8'hFD, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'hFE, 8'h22, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'hFE, 8'h00, 8'h03, 1'b0, 1'b0};

        presetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h00; pwdata[d] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d/pready", d), pready[d], 1'b0);
            check($sformatf("reset%0d/pslverr", d), pslverr[d], 1'b0);
            check($sformatf("reset%0d/prdata", d), prdata[d], 8'h00);
        end
        presetn = 1'b1;

        // Reset lands in the middle of a write's wait phase.
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h03; pwdata[0] = 8'h55;
        @(negedge clk);
        penable[0] = 1'b1;
        presetn    = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset/pready", pready[0], 1'b0);
        check("midreset/prdata", prdata[0], 8'h00);
        presetn = 1'b1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midreset/idle_pready", pready[0], 1'b0);
        end
        run(0, "midreset/read3", 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(0);
        run(0, "midreset/readcnt", 1'b0, 8'hFE, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(0);

        // PENABLE without a setup phase must not start a transfer.
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 8'h99;
        repeat (4) begin
            @(negedge clk);
            check("noset/pready", pready[0], 1'b0);
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        run(0, "noset/read2", 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        idle(0);

        for (int i = 0; i < 13; i++) begin
            run(0, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].scramble, vecs[i].rdata, vecs[i].err);
            idle(0);
        end

        // Abort: PSEL drops during the wait phase of a write to addr 9.
        run(0, "abort/pre_write", 1'b1, 8'h09, 8'h12, 1'b0, 8'h00, 1'b0);
        idle(0);
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h09; pwdata[0] = 8'h77;
        @(negedge clk);
        psel[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort/pready", pready[0], 1'b0);
        end
        run(0, "abort/read9", 1'b0, 8'h09, 8'h00, 1'b0, 8'h12, 1'b0);
        idle(0);
        run(0, "abort/readcnt", 1'b0, 8'hFE, 8'h00, 1'b0, 8'h04, 1'b0);
        idle(0);

        // Zero-wait instance: counter wrap over 257 back-to-back writes.
        for (int i = 0; i < 257; i++)
            run(1, $sformatf("cnt_wr%0d", i), 1'b1, 8'(i % 64), 8'(i), 1'b0, 8'h00, 1'b0);
        run(1, "cnt/read_wrap", 1'b0, 8'hFE, 8'h00, 1'b0, 8'h01, 1'b0);
        run(1, "cnt/write_fe", 1'b1, 8'hFE, 8'h22, 1'b0, 8'h00, 1'b1);
        run(1, "cnt/read_after", 1'b0, 8'hFE, 8'h00, 1'b0, 8'h01, 1'b0);
        run(1, "b2b/write1", 1'b1, 8'h01, 8'hAA, 1'b0, 8'h00, 1'b0);
        run(1, "b2b/read1", 1'b0, 8'h01, 8'h00, 1'b0, 8'hAA, 1'b0);
        idle(1);

        check("scoreboard/empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
